// File: rtl/systolic_matmul.sv
// Output-stationary NxN systolic matrix multiplier: C = A(NxK) x B(KxN).
// Operands are skewed into the grid, accumulated in place, then streamed out row-major.
module systolic_matmul #(
    parameter int N      = 3,
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    localparam int ACCW  = 2 * DW + $clog2(K)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [N*DW-1:0]   a_col,
    input  logic [N*DW-1:0]   b_row,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACCW-1:0]   res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_last,
    output logic              busy,
    output logic              done
);

    localparam int EXTW = ACCW - 2 * DW;
    localparam int NN   = N * N;
    localparam int BW   = $clog2(K + 1);
    localparam int DCW  = $clog2(2 * N);
    localparam int OW   = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   beat_cnt_q;
    logic [DCW-1:0]  drain_cnt_q;
    logic [OW-1:0]   out_idx_q;
    logic [OW-1:0]   nxt_idx;
    logic            in_ready_q;
    logic            res_valid_q;
    logic            res_last_q;
    logic            busy_q;
    logic            done_q;
    logic [ACCW-1:0] res_data_q;

    logic beat_v;
    logic acc_clr;

    // Skew shift registers, array edge inputs and the PE pipeline registers
    logic [DW-1:0]   a_sk_q   [N][N];
    logic            a_sk_v_q [N][N];
    logic [DW-1:0]   b_sk_q   [N][N];
    logic            b_sk_v_q [N][N];
    logic [DW-1:0]   a_edge   [N];
    logic            a_edge_v [N];
    logic [DW-1:0]   b_edge   [N];
    logic            b_edge_v [N];
    logic [DW-1:0]   a_q      [N][N];
    logic            av_q     [N][N];
    logic [DW-1:0]   b_q      [N][N];
    logic            bv_q     [N][N];
    logic [DW-1:0]   pe_a     [N][N];
    logic            pe_av    [N][N];
    logic [DW-1:0]   pe_b     [N][N];
    logic            pe_bv    [N][N];
    logic [ACCW-1:0] acc_q    [NN];
    logic [ACCW-1:0] acc_d    [NN];

    assign beat_v  = in_valid && in_ready_q;
    assign acc_clr = (state_q == S_IDLE) && start;
    assign nxt_idx = out_idx_q + OW'(1);

    genvar gi, gj;

    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign a_edge[gi]   = a_col[gi*DW +: DW];
                assign a_edge_v[gi] = beat_v;
                assign b_edge[gi]   = b_row[gi*DW +: DW];
                assign b_edge_v[gi] = beat_v;
            end else begin : g_delayed
                assign a_edge[gi]   = a_sk_q[gi][gi-1];
                assign a_edge_v[gi] = a_sk_v_q[gi][gi-1];
                assign b_edge[gi]   = b_sk_q[gi][gi-1];
                assign b_edge_v[gi] = b_sk_v_q[gi][gi-1];
            end

            for (gj = 0; gj < N; gj++) begin : g_stage
                always_ff @(posedge CLK) begin
                    if (!RST_N) begin
                        a_sk_q[gi][gj]   <= '0;
                        a_sk_v_q[gi][gj] <= 1'b0;
                        b_sk_q[gi][gj]   <= '0;
                        b_sk_v_q[gi][gj] <= 1'b0;
                    end else if (gj == 0) begin
                        a_sk_q[gi][gj]   <= a_col[gi*DW +: DW];
                        a_sk_v_q[gi][gj] <= beat_v;
                        b_sk_q[gi][gj]   <= b_row[gi*DW +: DW];
                        b_sk_v_q[gi][gj] <= beat_v;
                    end else begin
                        a_sk_q[gi][gj]   <= a_sk_q[gi][(gj > 0) ? gj - 1 : 0];
                        a_sk_v_q[gi][gj] <= a_sk_v_q[gi][(gj > 0) ? gj - 1 : 0];
                        b_sk_q[gi][gj]   <= b_sk_q[gi][(gj > 0) ? gj - 1 : 0];
                        b_sk_v_q[gi][gj] <= b_sk_v_q[gi][(gj > 0) ? gj - 1 : 0];
                    end
                end
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_pe
                logic [2*DW-1:0] ax;
                logic [2*DW-1:0] bx;
                logic [2*DW-1:0] prod;
                logic [ACCW-1:0] prod_x;

                if (gj == 0) begin : g_a_edge
                    assign pe_a[gi][gj]  = a_edge[gi];
                    assign pe_av[gi][gj] = a_edge_v[gi];
                end else begin : g_a_left
                    assign pe_a[gi][gj]  = a_q[gi][gj-1];
                    assign pe_av[gi][gj] = av_q[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign pe_b[gi][gj]  = b_edge[gj];
                    assign pe_bv[gi][gj] = b_edge_v[gj];
                end else begin : g_b_up
                    assign pe_b[gi][gj]  = b_q[gi-1][gj];
                    assign pe_bv[gi][gj] = bv_q[gi-1][gj];
                end

                // The low 2*DW bits of a 2*DW-wide product are exact for both encodings
                if (SIGNED != 0) begin : g_sext
                    assign ax = {{DW{pe_a[gi][gj][DW-1]}}, pe_a[gi][gj]};
                    assign bx = {{DW{pe_b[gi][gj][DW-1]}}, pe_b[gi][gj]};
                end else begin : g_zext
                    assign ax = {{DW{1'b0}}, pe_a[gi][gj]};
                    assign bx = {{DW{1'b0}}, pe_b[gi][gj]};
                end
                assign prod = ax * bx;

                if (EXTW == 0) begin : g_noext
                    assign prod_x = prod;
                end else if (SIGNED != 0) begin : g_pext_s
                    assign prod_x = {{EXTW{prod[2*DW-1]}}, prod};
                end else begin : g_pext_u
                    assign prod_x = {{EXTW{1'b0}}, prod};
                end

                assign acc_d[gi*N+gj] = acc_q[gi*N+gj] + prod_x;

                always_ff @(posedge CLK) begin
                    if (!RST_N) begin
                        a_q[gi][gj]     <= '0;
                        av_q[gi][gj]    <= 1'b0;
                        b_q[gi][gj]     <= '0;
                        bv_q[gi][gj]    <= 1'b0;
                        acc_q[gi*N+gj]  <= '0;
                    end else begin
                        a_q[gi][gj]  <= pe_a[gi][gj];
                        av_q[gi][gj] <= pe_av[gi][gj];
                        b_q[gi][gj]  <= pe_b[gi][gj];
                        bv_q[gi][gj] <= pe_bv[gi][gj];
                        if (acc_clr) begin
                            acc_q[gi*N+gj] <= '0;
                        end else if (pe_av[gi][gj] && pe_bv[gi][gj]) begin
                            acc_q[gi*N+gj] <= acc_d[gi*N+gj];
                        end
                    end
                end
            end
        end
    endgenerate

    // DRAIN lasts 2N-1 cycles: the last beat reaches PE(N-1,N-1) 2N-2 edges after it enters
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            out_idx_q   <= '0;
            in_ready_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        beat_cnt_q  <= '0;
                        drain_cnt_q <= '0;
                        out_idx_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat_v) begin
                        if (beat_cnt_q == BW'(K - 1)) begin
                            state_q     <= S_DRAIN;
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DCW'(2 * N - 2)) begin
                        state_q     <= S_OUT;
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc_q[0];
                        res_last_q  <= (NN == 1) ? 1'b1 : 1'b0;
                        out_idx_q   <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DCW'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (out_idx_q == OW'(NN - 1)) begin
                            state_q     <= S_IDLE;
                            res_valid_q <= 1'b0;
                            res_last_q  <= 1'b0;
                            res_data_q  <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_idx_q  <= nxt_idx;
                            res_data_q <= acc_q[nxt_idx];
                            res_last_q <= (nxt_idx == OW'(NN - 1));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
